sort_sequencer: RTL

SORT_SEQUENCER -- requirements
Module: sort_sequencer

---
 rtl/sort_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sort_sequencer.sv
// ============================================================================
// sort_sequencer
//
// Collects a batch of N unsigned DW-bit words, sorts them in place in
// ascending order by odd-even transposition, then streams them out smallest
// first. A single min/max compare-exchange unit is time-shared across all
// pairs, so SORT takes N*N/2 - N/2 cycles. Batches never overlap: the next
// batch is loaded only after the last word of the current batch has left.
//
// Ports
//   clk        sole clock, all state changes on the rising edge
//   rst        synchronous active-high reset, wins over every handshake
//   in_data    unsigned word to load
//   in_valid   in_data valid
//   in_ready   high in LOAD, block accepts a word
//   out_data   sorted word, buffer[rd_idx]
//   out_valid  high in DRAIN
//   out_ready  sink accepts out_data
//   out_last   out_data is the largest (final) word of the batch
//   busy       high in SORT and DRAIN
// ============================================================================
module sort_sequencer #(
    parameter int DW = 8,
    parameter int N  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Index constants, pre-cast to the counter width.
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [IW-1:0] LAST_EVEN = IW'(N - 2);  // last pair of an even pass
    localparam logic [IW-1:0] LAST_ODD  = IW'(N - 3);  // last pair of an odd pass
    localparam logic [IW-1:0] PENULT    = IW'(N - 2);  // rd index just before the last word

    // With a single pair the odd passes are empty, so pass 0 is also the
    // final pass.
    localparam bit ONE_PAIR = (N == 2);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SORT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   wr_q;
    logic [IW-1:0]   rd_q;
    logic [IW-1:0]   pass_q;
    logic [IW-1:0]   pair_q;
    logic [DW-1:0]   buf_q [N];

    logic            in_ready_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic            busy_q;

    // Shared compare-exchange unit.
    logic [IW-1:0]   pair_hi;
    logic [DW-1:0]   lo_d;
    logic [DW-1:0]   hi_d;
    logic            pass_end;
    logic            sort_done;

    // Returns {max, min}. Equal operands come back in their original
    // positions, so the buffer is left unchanged.
    function automatic logic [2*DW-1:0] cmp_exch(input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
        if (a > b) begin
            return {a, b};
        end
        return {b, a};
    endfunction

    assign pair_hi = pair_q + IW'(1);

    always_comb begin
        {hi_d, lo_d} = cmp_exch(buf_q[pair_q], buf_q[pair_hi]);
    end

    // Even passes walk pairs 0,2,..,N-2; odd passes walk 1,3,..,N-3.
    assign pass_end  = pass_q[0] ? (pair_q == LAST_ODD) : (pair_q == LAST_EVEN);
    assign sort_done = pass_end && ((pass_q == LAST_IDX) || ONE_PAIR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            wr_q        <= '0;
            rd_q        <= '0;
            pass_q      <= '0;
            pair_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        buf_q[wr_q] <= in_data;
                        if (wr_q == LAST_IDX) begin
                            state_q    <= S_SORT;
                            wr_q       <= '0;
                            pass_q     <= '0;
                            pair_q     <= '0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end else begin
                            wr_q <= wr_q + IW'(1);
                        end
                    end
                end

                S_SORT: begin
                    buf_q[pair_q]  <= lo_d;
                    buf_q[pair_hi] <= hi_d;
                    if (sort_done) begin
                        state_q     <= S_DRAIN;
                        rd_q        <= '0;
                        pass_q      <= '0;
                        pair_q      <= '0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                    end else if (pass_end) begin
                        // Next pass starts on pair 1 if it is odd, pair 0 if even.
                        pass_q <= pass_q + IW'(1);
                        pair_q <= pass_q[0] ? IW'(0) : IW'(1);
                    end else begin
                        pair_q <= pair_q + IW'(2);
                    end
                end

                S_DRAIN: begin
                    if (out_ready) begin
                        if (rd_q == LAST_IDX) begin
                            state_q     <= S_LOAD;
                            rd_q        <= '0;
                            wr_q        <= '0;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                        end else begin
                            rd_q       <= rd_q + IW'(1);
                            out_last_q <= (rd_q == PENULT);
                        end
                    end
                end

                default: begin
                    state_q     <= S_LOAD;
                    wr_q        <= '0;
                    rd_q        <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign out_data  = buf_q[rd_q];

endmodule
